// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file: pipeline has fixed priority, long-latency
// results wait in a 1-entry buffer, and a pending bitmap stalls decode. Optional: WB_BYPASS_EN.
module regs_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        reg_wen_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_valid,
  output logic        stall_o,
  output logic        pipe_hold_o,
  output logic        dbg_state_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_BUF, SRC_BYP} src_e;

  state_e      state_q, state_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] pending_q, pending_d;
  logic [3:0]  starve_q, starve_d;
  src_e        src;
  logic        accept;
  logic        pipe_req;

  // Handshake: a result transfers in any cycle where lu_valid && lu_ready; lu_ready
  // depends only on buffer occupancy, never on lu_valid.
  assign lu_ready    = (state_q == EMPTY);
  assign accept      = lu_valid && lu_ready;
  assign pipe_req    = pipe_wen && (pipe_waddr != 5'd0);
  assign pipe_hold_o = (state_q == HELD) && (starve_q == STARVE_LIM);
  assign dbg_state_o = state_q;

  // pending_q[0] is held at zero, so x0 sources can never stall decode.
  assign stall_o = id_valid && (pending_q[id_rs1] | pending_q[id_rs2] | pending_q[id_rd]);

  always_comb begin
    src = SRC_NONE;
    if (pipe_hold_o) src = SRC_BUF;
    else if (pipe_req) src = SRC_PIPE;
    else if (state_q == HELD) src = SRC_BUF;
`ifdef WB_BYPASS_EN
    else if (accept && (lu_rd != 5'd0)) src = SRC_BYP;
`endif
  end

  always_comb begin
    reg_wen_o   = (src != SRC_NONE);
    reg_waddr_o = 5'd0;
    reg_wdata_o = 32'd0;
    case (src)
      SRC_PIPE: begin reg_waddr_o = pipe_waddr; reg_wdata_o = pipe_wdata; end
      SRC_BUF:  begin reg_waddr_o = buf_rd_q;   reg_wdata_o = buf_data_q; end
      SRC_BYP:  begin reg_waddr_o = lu_rd;      reg_wdata_o = lu_data;    end
      default:  ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    starve_d   = starve_q;
    case (state_q)
      EMPTY: begin
        starve_d = 4'd0;
        // Results to x0 are swallowed here: accepted but never buffered.
        if (accept && (lu_rd != 5'd0) && (src != SRC_BYP)) begin
          state_d    = HELD;
          buf_rd_d   = lu_rd;
          buf_data_d = lu_data;
        end
      end
      HELD: begin
        if (src == SRC_BUF) begin
          state_d  = EMPTY;
          starve_d = 4'd0;
        end else if (starve_q != STARVE_LIM) begin
          starve_d = starve_q + 4'd1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Clears are applied before the set so a same-cycle set of the same bit wins.
  always_comb begin
    pending_d = pending_q;
    if (src == SRC_BUF) pending_d[buf_rd_q] = 1'b0;
    if (src == SRC_BYP) pending_d[lu_rd] = 1'b0;
    if (lu_issue && !stall_o && (lu_issue_rd != 5'd0)) pending_d[lu_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      buf_rd_q   <= 5'd0;
      buf_data_q <= 32'd0;
      pending_q  <= 32'd0;
      starve_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      pending_q  <= pending_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter: directed vector table, reset/bypass sequences and a
// randomized phase checked against a queue-based reference model.
module tb_regs_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_valid;
  logic        stall_o;
  logic        pipe_hold_o;
  logic        dbg_state_o;

  regs_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_valid(id_valid),
    .stall_o(stall_o), .pipe_hold_o(pipe_hold_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         m_buf[$];
  logic [31:0] m_pend;
  int          m_wait;
  int          e_src;  // 0 none, 1 pipeline, 2 buffer, 3 bypass
  logic        e_wen, e_rdy, e_stall, e_hold;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  task automatic model_reset();
    m_buf.delete();
    m_pend = 32'd0;
    m_wait = 0;
  endtask

  function automatic logic pend_at(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  task automatic model_comb();
    e_hold  = (m_buf.size() > 0) && (m_wait == STARVE_MAX);
    e_rdy   = (m_buf.size() == 0);
    e_stall = id_valid && (pend_at(id_rs1) || pend_at(id_rs2) || pend_at(id_rd));
    e_src   = 0;
    if (e_hold) e_src = 2;
    else if (pipe_wen && pipe_waddr != 5'd0) e_src = 1;
    else if (m_buf.size() > 0) e_src = 2;
`ifdef WB_BYPASS_EN
    else if (lu_valid && lu_rd != 5'd0) e_src = 3;
`endif
    e_wen  = (e_src != 0);
    e_addr = 5'd0;
    e_data = 32'd0;
    if (e_src == 1) begin e_addr = pipe_waddr;   e_data = pipe_wdata;   end
    if (e_src == 2) begin e_addr = m_buf[0].rd;  e_data = m_buf[0].data; end
    if (e_src == 3) begin e_addr = lu_rd;        e_data = lu_data;      end
  endtask

  task automatic model_seq();
    wb_t item;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_buf.size() > 0) begin
      if (e_src == 2) begin
        m_pend[m_buf[0].rd] = 1'b0;
        m_buf.delete(0);
        m_wait = 0;
      end else if (m_wait < STARVE_MAX) begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
      if (lu_valid && lu_rd != 5'd0) begin
        if (e_src == 3) m_pend[lu_rd] = 1'b0;
        else begin
          item.rd   = lu_rd;
          item.data = lu_data;
          m_buf.push_back(item);
        end
      end
    end
    if (lu_issue && !e_stall && lu_issue_rd != 5'd0) m_pend[lu_issue_rd] = 1'b1;
  endtask

  task automatic check_model();
    chk("model.reg_wen", 32'(reg_wen_o), 32'(e_wen));
    if (e_wen) begin
      chk("model.reg_waddr", 32'(reg_waddr_o), 32'(e_addr));
      chk("model.reg_wdata", reg_wdata_o, e_data);
    end
    chk("model.lu_ready", 32'(lu_ready), 32'(e_rdy));
    chk("model.stall", 32'(stall_o), 32'(e_stall));
    chk("model.pipe_hold", 32'(pipe_hold_o), 32'(e_hold));
    chk("model.held", 32'(dbg_state_o), 32'(m_buf.size() > 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    pipe_wen = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    lu_issue = 1'b0; lu_issue_rd = 5'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
  endtask

  task automatic cycle();
    model_comb();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  typedef struct {
    logic        pw;  logic [4:0] pa;  logic [31:0] pd;
    logic        iss; logic [4:0] iss_rd;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        idv; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic        e_wen; logic [4:0] e_addr; logic [31:0] e_data;
    logic        e_rdy; logic e_stall; logic e_hold;
  } vec_t;

  function automatic vec_t mk(input int pw, pa, pd, iss, iss_rd, lv, lrd, ld,
                              idv, rs1, rs2, rd, ew, ea, ed, er, es, eh);
    vec_t v;
    v.pw = pw[0];   v.pa = 5'(pa);   v.pd = 32'(pd);
    v.iss = iss[0]; v.iss_rd = 5'(iss_rd);
    v.lv = lv[0];   v.lrd = 5'(lrd); v.ld = 32'(ld);
    v.idv = idv[0]; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.e_wen = ew[0]; v.e_addr = 5'(ea); v.e_data = 32'(ed);
    v.e_rdy = er[0]; v.e_stall = es[0]; v.e_hold = eh[0];
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    pipe_wen = v.pw; pipe_waddr = v.pa; pipe_wdata = v.pd;
    lu_issue = v.iss; lu_issue_rd = v.iss_rd;
    lu_valid = v.lv; lu_rd = v.lrd; lu_data = v.ld;
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    model_comb();
    @(negedge clk);
    chk({tag, ".reg_wen"}, 32'(reg_wen_o), 32'(v.e_wen));
    if (v.e_wen) begin
      chk({tag, ".reg_waddr"}, 32'(reg_waddr_o), 32'(v.e_addr));
      chk({tag, ".reg_wdata"}, reg_wdata_o, v.e_data);
    end
    chk({tag, ".lu_ready"}, 32'(lu_ready), 32'(v.e_rdy));
    chk({tag, ".stall"}, 32'(stall_o), 32'(v.e_stall));
    chk({tag, ".pipe_hold"}, 32'(pipe_hold_o), 32'(v.e_hold));
    check_model();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    //            pw pa pd           iss ird lv lrd ld              idv rs1 rs2 rd  ew ea ed             er es eh
    vecs.push_back(mk(0, 0, 0,          1, 5,  0, 0, 0,             0, 0, 0, 0,  0, 0, 0,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             1, 5, 0, 0,  0, 0, 0,            1, 1, 0));
    vecs.push_back(mk(1, 7, 'h11,       0, 0,  1, 5, 32'hDEADBEEF,  0, 0, 0, 0,  1, 7, 'h11,         1, 0, 0));
    vecs.push_back(mk(1, 7, 'h22,       0, 0,  0, 0, 0,             1, 0, 5, 0,  1, 7, 'h22,         0, 1, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             1, 5, 0, 0,  1, 5, 32'hDEADBEEF, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             1, 5, 0, 0,  0, 0, 0,            1, 0, 0));
    // scoreboard: issue to x9, stalled issue to x10 must not set its bit
    vecs.push_back(mk(0, 0, 0,          1, 9,  0, 0, 0,             1, 0, 0, 0,  0, 0, 0,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             1, 0, 9, 0,  0, 0, 0,            1, 1, 0));
    vecs.push_back(mk(0, 0, 0,          1, 10, 0, 0, 0,             1, 0, 0, 9,  0, 0, 0,            1, 1, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             1, 10, 0, 0, 0, 0, 0,            1, 0, 0));
    vecs.push_back(mk(1, 1, 'h1,        0, 0,  1, 9, 'h99,          1, 0, 9, 0,  1, 1, 'h1,          1, 1, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             1, 0, 9, 0,  1, 9, 'h99,         0, 1, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             1, 0, 9, 0,  0, 0, 0,            1, 0, 0));
    // starvation: pipeline claims the port every cycle
    vecs.push_back(mk(0, 0, 0,          1, 6,  0, 0, 0,             0, 0, 0, 0,  0, 0, 0,            1, 0, 0));
    vecs.push_back(mk(1, 2, 'hA0,       0, 0,  1, 6, 'h66,          0, 0, 0, 0,  1, 2, 'hA0,         1, 0, 0));
    vecs.push_back(mk(1, 2, 'hA1,       0, 0,  0, 0, 0,             0, 0, 0, 0,  1, 2, 'hA1,         0, 0, 0));
    vecs.push_back(mk(1, 2, 'hA2,       0, 0,  0, 0, 0,             0, 0, 0, 0,  1, 2, 'hA2,         0, 0, 0));
    vecs.push_back(mk(1, 2, 'hA3,       0, 0,  0, 0, 0,             0, 0, 0, 0,  1, 2, 'hA3,         0, 0, 0));
    vecs.push_back(mk(1, 2, 'hA4,       0, 0,  0, 0, 0,             0, 0, 0, 0,  1, 2, 'hA4,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             1, 6, 0, 0,  1, 6, 'h66,         0, 1, 1));
    vecs.push_back(mk(1, 3, 'hA5,       0, 0,  0, 0, 0,             1, 6, 0, 0,  1, 3, 'hA5,         1, 0, 0));
    // x0 handling
    vecs.push_back(mk(1, 7, 'h70,       0, 0,  1, 8, 'h88,          0, 0, 0, 0,  1, 7, 'h70,         1, 0, 0));
    vecs.push_back(mk(1, 0, 'h55,       0, 0,  0, 0, 0,             0, 0, 0, 0,  1, 8, 'h88,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  1, 0, 32'h12345678,  0, 0, 0, 0,  0, 0, 0,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,  0, 0, 0,             0, 0, 0, 0,  0, 0, 0,            1, 0, 0));

    // reset state
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.reg_wen", 32'(reg_wen_o), 32'd0);
    chk("reset.reg_waddr", 32'(reg_waddr_o), 32'd0);
    chk("reset.reg_wdata", reg_wdata_o, 32'd0);
    chk("reset.lu_ready", 32'(lu_ready), 32'd1);
    chk("reset.stall", 32'(stall_o), 32'd0);
    chk("reset.pipe_hold", 32'(pipe_hold_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("v%0d", i));

    // reset while HELD with pending[5] set
    drive_idle(); lu_issue = 1'b1; lu_issue_rd = 5'd5;
    cycle();
    drive_idle(); pipe_wen = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hCAFE0005;
    cycle();
    drive_idle(); id_valid = 1'b1; id_rs1 = 5'd5;
    #1;
    chk("midrst.pre_held", 32'(dbg_state_o), 32'd1);
    chk("midrst.pre_stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.reg_wen", 32'(reg_wen_o), 32'd0);
    chk("midrst.reg_waddr", 32'(reg_waddr_o), 32'd0);
    chk("midrst.reg_wdata", reg_wdata_o, 32'd0);
    chk("midrst.lu_ready", 32'(lu_ready), 32'd1);
    chk("midrst.stall", 32'(stall_o), 32'd0);
    chk("midrst.pipe_hold", 32'(pipe_hold_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0), "postrst");

    // bypass versus buffered accept-to-write latency
`ifdef WB_BYPASS_EN
    apply_vec(mk(0, 0, 0, 0, 0, 1, 3, 'h33, 0, 0, 0, 0, 1, 3, 'h33, 1, 0, 0), "byp0");
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "byp1");
`else
    apply_vec(mk(0, 0, 0, 0, 0, 1, 3, 'h33, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "byp0");
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h33, 0, 0, 0), "byp1");
`endif

    // randomized phase against the model
    for (int n = 0; n < 400; n++) begin
      logic hold_now;
      hold_now    = (m_buf.size() > 0) && (m_wait == STARVE_MAX);
      pipe_wen    = hold_now ? 1'b0 : ($urandom_range(0, 99) < 60);
      pipe_waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_wdata  = $urandom;
      lu_issue    = ($urandom_range(0, 3) == 0);
      lu_issue_rd = 5'($urandom_range(0, 7));
      lu_valid    = ($urandom_range(0, 2) == 0);
      lu_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      lu_data     = $urandom;
      id_valid    = ($urandom_range(0, 1) == 1);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom_range(0, 7));
      cycle();
    end

    drive_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
